// File: rtl/sha_sched_pkg.sv
// Shared types for the SHA job scheduler: FSM state encoding and the job
// descriptor that travels through the job FIFO.
package sha_sched_pkg;

    localparam int TAG_W  = 4;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_RECOVER,
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_CPL
    } sched_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] msg_addr;
        logic [ADDR_W-1:0] out_addr;
        logic [TAG_W-1:0]  tag;
    } sha_job_t;

endpackage

// File: rtl/sha_job_fifo.sv
// Small synchronous FIFO of job descriptors. The head entry is presented
// combinationally so the scheduler can latch it on the same edge it pops.
module sha_job_fifo
    import sha_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  sha_job_t               i_wdata,
    input  logic                   i_pop,
    output sha_job_t               o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    sha_job_t       r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Descriptor storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/sha_job_scheduler.sv
// Sequences queued hash jobs onto a single SHA core: launch with a start
// pulse, wait for done or timeout, report a tagged completion, then hold the
// core in reset for a few cycles so it is back in its idle state.
module sha_job_scheduler
    import sha_sched_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_W          = sha_sched_pkg::TAG_W,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int RESET_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [15:0]      job_msg_addr,
    input  logic [15:0]      job_out_addr,
    input  logic [TAG_W-1:0] job_tag,
    output logic             core_start,
    output logic [15:0]      core_message_addr,
    output logic [15:0]      core_output_addr,
    input  logic             core_done,
    output logic             core_reset_n,
    output logic             cpl_valid,
    input  logic             cpl_ready,
    output logic [TAG_W-1:0] cpl_tag,
    output logic             cpl_timeout,
    output logic             busy,
    output logic [15:0]      jobs_done
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

    sched_state_t     r_state;
    logic [RST_W-1:0] r_rst_cnt;
    logic [TMR_W-1:0] r_timer;
    logic             r_core_reset_n;
    logic             r_core_start;
    logic [15:0]      r_core_msg;
    logic [15:0]      r_core_out;
    logic [TAG_W-1:0] r_job_tag;
    logic             r_cpl_valid;
    logic [TAG_W-1:0] r_cpl_tag;
    logic             r_cpl_timeout;
    logic [15:0]      r_jobs_done;

    sha_job_t         w_push_job;
    sha_job_t         w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    // Ready depends only on pre-edge occupancy, so a full FIFO refuses a push
    // even when the scheduler pops on the same edge.
    assign job_ready  = !w_fifo_full;
    assign w_push     = job_valid && job_ready;
    assign w_pop      = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_push_job = '{msg_addr: job_msg_addr, out_addr: job_out_addr, tag: job_tag};

    sha_job_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_push_job),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Scheduler FSM with timer, core reset pulse, completion and success counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_RECOVER;
            r_rst_cnt      <= '0;
            r_timer        <= '0;
            r_core_reset_n <= 1'b0;
            r_core_start   <= 1'b0;
            r_core_msg     <= '0;
            r_core_out     <= '0;
            r_job_tag      <= '0;
            r_cpl_valid    <= 1'b0;
            r_cpl_tag      <= '0;
            r_cpl_timeout  <= 1'b0;
            r_jobs_done    <= '0;
        end else begin
            case (r_state)
                ST_RECOVER: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_core_reset_n <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_core_msg   <= w_head.msg_addr;
                        r_core_out   <= w_head.out_addr;
                        r_job_tag    <= w_head.tag;
                        r_core_start <= 1'b1;
                        r_state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_core_start <= 1'b0;
                    r_timer      <= '0;
                    r_state      <= ST_RUN;
                end
                ST_RUN: begin
                    // Done takes priority over an expiry on the same cycle.
                    if (core_done) begin
                        r_cpl_valid   <= 1'b1;
                        r_cpl_timeout <= 1'b0;
                        r_cpl_tag     <= r_job_tag;
                        r_state       <= ST_CPL;
                    end else if (r_timer == TMR_LAST) begin
                        r_cpl_valid   <= 1'b1;
                        r_cpl_timeout <= 1'b1;
                        r_cpl_tag     <= r_job_tag;
                        r_state       <= ST_CPL;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_CPL: begin
                    if (cpl_ready) begin
                        r_cpl_valid    <= 1'b0;
                        r_core_reset_n <= 1'b0;
                        r_rst_cnt      <= '0;
                        r_state        <= ST_RECOVER;
                        if (!r_cpl_timeout) r_jobs_done <= r_jobs_done + 1'b1;
                    end
                end
                default: r_state <= ST_RECOVER;
            endcase
        end
    end

    assign core_start        = r_core_start;
    assign core_message_addr = r_core_msg;
    assign core_output_addr  = r_core_out;
    assign core_reset_n      = r_core_reset_n;
    assign cpl_valid         = r_cpl_valid;
    assign cpl_tag           = r_cpl_tag;
    assign cpl_timeout       = r_cpl_timeout;
    assign jobs_done         = r_jobs_done;
    assign busy              = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Bench for sha_job_scheduler: a behavioural SHA core model answers start
// pulses after a per-job delay, expected launches and completions are queued
// at submission, and a negedge monitor compares everything the DUT presents.
module tb_sha_job_scheduler;

    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int TMO   = 200;
    localparam int RST   = 2;
    localparam int NEVER = 65535;

    logic          clk;
    logic          reset_n;
    logic          job_valid;
    logic          job_ready;
    logic [15:0]   job_msg_addr;
    logic [15:0]   job_out_addr;
    logic [TW-1:0] job_tag;
    logic          core_start;
    logic [15:0]   core_message_addr;
    logic [15:0]   core_output_addr;
    logic          core_done = 1'b0;
    logic          core_reset_n;
    logic          cpl_valid;
    logic          cpl_ready = 1'b0;
    logic [TW-1:0] cpl_tag;
    logic          cpl_timeout;
    logic          busy;
    logic [15:0]   jobs_done;

    typedef struct {
        logic [15:0]   msg;
        logic [15:0]   out;
        logic [TW-1:0] tag;
        int            dly;
    } job_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic          to;
    } cpl_t;

    job_t launch_q[$];
    cpl_t cpl_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_launch = 0;
    int   exp_done = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   cnt = 0;
    int   vcyc = 0;
    int   rst_low = 0;
    bit   armed = 0;
    bit   running = 0;
    bit   in_cpl = 0;
    bit   prev_start = 0;
    bit   saw_reset = 0;
    bit   stall_mode = 0;
    job_t cur;

    sha_job_scheduler #(
        .FIFO_DEPTH     (DEPTH),
        .TAG_W          (TW),
        .TIMEOUT_CYCLES (TMO),
        .RESET_CYCLES   (RST)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_msg_addr      (job_msg_addr),
        .job_out_addr      (job_out_addr),
        .job_tag           (job_tag),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done),
        .core_reset_n      (core_reset_n),
        .cpl_valid         (cpl_valid),
        .cpl_ready         (cpl_ready),
        .cpl_tag           (cpl_tag),
        .cpl_timeout       (cpl_timeout),
        .busy              (busy),
        .jobs_done         (jobs_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Expected cycles from the start pulse to the first completion cycle:
    // the core answers after dly cycles, or the job is cut off at TMO.
    function automatic int exp_latency(int dly);
        return 1 + ((dly > TMO) ? TMO : dly);
    endfunction

    // Core model, launch/address checks and completion monitor.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            saw_reset  = 1;
            armed      = 0;
            core_done  = 0;
            running    = 0;
            in_cpl     = 0;
            cpl_ready  = 0;
            prev_start = 0;
            exp_done   = 0;
            n_launch   = 0;
            launch_q.delete();
            cpl_q.delete();
        end else begin
            if (!core_reset_n) begin
                armed     = 0;
                core_done = 0;
            end else if (armed) begin
                cnt++;
                if (cnt == cur.dly) core_done = 1;
            end

            if (core_start) begin
                chk("start_pulse_width", prev_start, 0);
                if (!prev_start) begin
                    chk("launch_expected", launch_q.size() != 0, 1);
                    if (launch_q.size() != 0) begin
                        cur = launch_q.pop_front();
                        chk("launch_msg_addr", core_message_addr, cur.msg);
                        chk("launch_out_addr", core_output_addr, cur.out);
                        armed     = 1;
                        cnt       = 0;
                        running   = 1;
                        start_cyc = cyc;
                        n_launch++;
                    end
                end
            end else if (running) begin
                chk("held_msg_addr", core_message_addr, cur.msg);
                chk("held_out_addr", core_output_addr, cur.out);
            end
            prev_start = core_start;

            if (cpl_valid) begin
                if (cpl_q.size() == 0) begin
                    chk("cpl_expected", cpl_q.size(), 1);
                    cpl_ready = 1;
                end else begin
                    if (!in_cpl) begin
                        in_cpl = 1;
                        vcyc   = 0;
                        chk("cpl_latency", cyc - start_cyc, exp_latency(cur.dly));
                    end
                    chk("cpl_tag", cpl_tag, cpl_q[0].tag);
                    chk("cpl_timeout", cpl_timeout, cpl_q[0].to);
                    chk("no_start_during_cpl", core_start, 0);
                    vcyc++;
                    if (stall_mode && vcyc <= 50) cpl_ready = 0;
                    else cpl_ready = ($urandom_range(0, 3) != 0);
                    if (cpl_ready) begin
                        chk("jobs_done", jobs_done, exp_done);
                        if (!cpl_q[0].to) exp_done = (exp_done + 1) & 16'hFFFF;
                        void'(cpl_q.pop_front());
                        in_cpl  = 0;
                        running = 0;
                    end
                end
            end else begin
                cpl_ready = ($urandom_range(0, 1) != 0);
            end
        end

        if (!core_reset_n) begin
            rst_low++;
        end else begin
            if (rst_low != 0 && !saw_reset) chk("core_reset_low_cycles", rst_low, RST);
            if (rst_low != 0) saw_reset = 0;
            rst_low = 0;
        end
    end

    task automatic push_job(input logic [15:0] msg, input logic [15:0] out,
                            input logic [TW-1:0] tag, input int dly);
        job_t j;
        cpl_t c;
        int   w = 0;
        @(negedge clk);
        while (!job_ready && w < 2000) begin
            job_valid = 0;
            @(negedge clk);
            w++;
        end
        if (!job_ready) begin
            chk("push_ready_within_budget", job_ready, 1);
            job_valid = 0;
        end else begin
            job_valid    = 1;
            job_msg_addr = msg;
            job_out_addr = out;
            job_tag      = tag;
            j.msg = msg;
            j.out = out;
            j.tag = tag;
            j.dly = dly;
            launch_q.push_back(j);
            c.tag = tag;
            c.to  = (dly > TMO);
            cpl_q.push_back(c);
            n_acc++;
        end
    endtask

    task automatic end_push();
        @(negedge clk);
        job_valid = 0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((busy || cpl_q.size() != 0 || launch_q.size() != 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_pending", cpl_q.size(), 0);
    endtask

    function automatic int pick_delay();
        case ($urandom_range(0, 5))
            0:       return TMO;
            1:       return TMO + 1;
            2:       return NEVER;
            default: return $urandom_range(1, 60);
        endcase
    endfunction

    initial begin
        reset_n      = 0;
        job_valid    = 0;
        job_msg_addr = 0;
        job_out_addr = 0;
        job_tag      = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_core_reset_n", core_reset_n, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_msg", core_message_addr, 0);
        chk("rst_core_out", core_output_addr, 0);
        chk("rst_cpl_valid", cpl_valid, 0);
        chk("rst_cpl_tag", cpl_tag, 0);
        chk("rst_cpl_timeout", cpl_timeout, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_job_ready", job_ready, 1);
        chk("rst_busy", busy, 1);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk); #1;
        chk("recover1_core_reset_n", core_reset_n, 0);
        chk("recover1_busy", busy, 1);
        @(negedge clk); #1;
        chk("idle_core_reset_n", core_reset_n, 1);
        chk("idle_busy", busy, 0);

        // Single job, core answers after 150 cycles
        push_job(16'h0000, 16'h0100, 4'd3, 150);
        end_push(); #1;
        chk("t1_start_before", core_start, 0);
        @(negedge clk); #1;
        chk("t1_start_pulse", core_start, 1);
        @(negedge clk); #1;
        chk("t1_start_after", core_start, 0);
        wait_drain();
        chk("t1_jobs_done", jobs_done, 1);

        // Five back-to-back jobs fill the FIFO behind the running one
        for (int i = 0; i < 5; i++)
            push_job(16'(16'h1000 + i * 16), 16'(16'h1800 + i * 16), 4'(i), $urandom_range(5, 40));
        end_push(); #1;
        chk("fifo_full_job_ready", job_ready, (n_acc - n_launch) != DEPTH);
        wait_drain();

        // Timeout, then the following job still launches
        push_job(16'h2000, 16'h2100, 4'd5, NEVER);
        push_job(16'h2200, 16'h2300, 4'd6, 10);
        end_push();
        wait_drain();

        // Done exactly on, just before and just after the expiry cycle
        push_job(16'h2400, 16'h2500, 4'd7, TMO);
        push_job(16'h2600, 16'h2700, 4'd8, TMO + 1);
        push_job(16'h2800, 16'h2900, 4'd9, TMO - 1);
        end_push();
        wait_drain();

        // Completion held for 50 cycles with another job waiting
        stall_mode = 1;
        push_job(16'h3000, 16'h3100, 4'd10, 5);
        push_job(16'h3200, 16'h3300, 4'd11, 5);
        end_push();
        wait_drain();
        stall_mode = 0;

        // Randomized jobs with random gaps and completion back-pressure
        for (int i = 0; i < 16; i++) begin
            push_job(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), pick_delay());
            if ($urandom_range(0, 2) == 0) end_push();
        end
        end_push();
        wait_drain();
        chk("pre_reset_jobs_done", jobs_done, exp_done);

        // Reset while a job runs with two more queued
        push_job(16'h4000, 16'h4100, 4'd12, NEVER);
        push_job(16'h4200, 16'h4300, 4'd13, 5);
        push_job(16'h4400, 16'h4500, 4'd14, 5);
        end_push();
        repeat (30) @(negedge clk);
        n_acc   = 0;
        reset_n = 0;
        @(negedge clk); #1;
        chk("midrst_core_reset_n", core_reset_n, 0);
        chk("midrst_cpl_valid", cpl_valid, 0);
        chk("midrst_job_ready", job_ready, 1);
        chk("midrst_jobs_done", jobs_done, 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk); #1;
        chk("midrst_recover_busy", busy, 1);
        @(negedge clk); #1;
        chk("midrst_idle_busy", busy, 0);
        chk("midrst_idle_core_reset_n", core_reset_n, 1);
        chk("midrst_idle_jobs_done", jobs_done, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("midrst_no_cpl", cpl_valid, 0);

        // Normal operation resumes after the reset
        push_job(16'h5000, 16'h5100, 4'd15, 8);
        end_push();
        wait_drain();
        chk("final_jobs_done", jobs_done, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
